ram_arbiter: RTL and testbench

Shares the single-port 16×8 program/data RAM between the CPU microcode datapath and a host load/debug port. It owns the CPU memory address register (MAR) and drives the RAM address, write-enable and write-data pins. It grants the host one-cycle access slots and stalls the CPU whenever a host slot collides with a CPU RAM access. It sits between the control unit's MI/RI/RO strobes, the shared bus and the RAM array.

---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arbiter_if.sv | 26 ++
 rtl/ram_arbiter.sv | 115 +++++++++++
 tb/tb_ram_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: default widths, FSM state type and
// the control-word bit positions of the RAM-related microcode strobes.
package ram_arbiter_pkg;

    localparam int unsigned RAM_ADDR_W   = 4;
    localparam int unsigned RAM_DATA_W   = 8;
    localparam int unsigned RAM_MAX_WAIT = 8;

    // Control-word bit positions driven by the control unit
    localparam int unsigned CTRL_HLT_BIT = 15;
    localparam int unsigned CTRL_MI_BIT  = 14;
    localparam int unsigned CTRL_RI_BIT  = 13;
    localparam int unsigned CTRL_RO_BIT  = 12;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOST = 2'd1,
        ARB_ACK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Host load/debug port of the RAM arbiter: level request, one-cycle ack pulse.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU datapath and the
// host port; owns the MAR and stalls the CPU when a host slot steals the port.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = RAM_ADDR_W,
    parameter int unsigned DATA_W   = RAM_DATA_W,
    parameter int unsigned MAX_WAIT = RAM_MAX_WAIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_mi,
    input  logic               cpu_ri,
    input  logic               cpu_ro,
    input  logic               cpu_halt,
    input  logic [DATA_W-1:0]  cpu_bus,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_stall,
    ram_arbiter_if.slave       host,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] mar_q;
    logic              lat_we_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              cpu_access;
    logic              grant;

    assign cpu_access = cpu_ri | cpu_ro;

    // Host wins when the CPU is not using the RAM, or it has waited long enough
    assign grant = (state_q == ARB_IDLE) && host.req &&
                   (cpu_halt || !cpu_access || (wait_q == WAIT_MAX));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ram_addr  = mar_q;
        ram_we    = cpu_ri;
        ram_wdata = cpu_bus;
        cpu_stall = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d = ARB_HOST;
                    wait_d  = '0;
                end else if (host.req) begin
                    if (wait_q != WAIT_MAX) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            ARB_HOST: begin
                ram_addr  = lat_addr_q;
                ram_we    = lat_we_q;
                ram_wdata = lat_wdata_q;
                cpu_stall = cpu_access;
                state_d   = ARB_ACK;
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            wait_q      <= '0;
            mar_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (cpu_mi && !cpu_stall) begin
                mar_q <= cpu_bus[ADDR_W-1:0];
            end
            if (grant) begin
                lat_we_q    <= host.we;
                lat_addr_q  <= host.addr;
                lat_wdata_q <= host.wdata;
            end
            ack_q <= (state_q == ARB_HOST);
            // Read data is held across host writes until the next read ack
            if ((state_q == ARB_HOST) && !lat_we_q) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    assign cpu_rdata  = ram_rdata;
    assign host.ack   = ack_q;
    assign host.rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed CPU/host sequences with a
// behavioural 16x8 RAM and an ack monitor checking data and latency.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    typedef struct {
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_mi, cpu_ri, cpu_ro, cpu_halt;
    logic [7:0] cpu_bus, cpu_rdata;
    logic       cpu_stall;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata, ram_rdata;
    logic [7:0] mem [16];

    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   stalls = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(RAM_ADDR_W), .DATA_W(RAM_DATA_W)) host_bus ();

    ram_arbiter #(
        .ADDR_W  (RAM_ADDR_W),
        .DATA_W  (RAM_DATA_W),
        .MAX_WAIT(RAM_MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_mi   (cpu_mi),
        .cpu_ri   (cpu_ri),
        .cpu_ro   (cpu_ro),
        .cpu_halt (cpu_halt),
        .cpu_bus  (cpu_bus),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .host     (host_bus),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cpu_stall) stalls <= stalls + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (host_bus.ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("host_rdata", 32'(host_bus.rdata), 32'(e.rdata));
                check("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_start(input logic we, input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] exp_rd, input int lat, input bit expect_ack);
        exp_t e;
        host_bus.req   = 1'b1;
        host_bus.we    = we;
        host_bus.addr  = a;
        host_bus.wdata = d;
        if (expect_ack) begin
            e.rdata = exp_rd;
            e.cyc   = cyc + lat;
            sb.push_back(e);
        end
    endtask

    // Returns at the negedge of the ack cycle with req already dropped
    task automatic host_wait_ack(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_bus.ack) begin
                got = 1'b1;
                break;
            end
        end
        host_bus.req = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_ack_timeout: got no ack expected ack within 20 cycles", name);
        end
    endtask

    initial begin
        int s0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[3] = 8'h55;
        mem[9] = 8'h11;
        cpu_mi = 0; cpu_ri = 0; cpu_ro = 0; cpu_halt = 0; cpu_bus = 8'h00;
        host_bus.req = 0; host_bus.we = 0; host_bus.addr = 4'h0; host_bus.wdata = 8'h00;

        // Reset values
        @(negedge clk);
        check("rst_stall", 32'(cpu_stall), 0);
        check("rst_ack", 32'(host_bus.ack), 0);
        check("rst_rdata", 32'(host_bus.rdata), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        step();
        rst = 0;
        step();

        // CPU write path: MAR <= 14, RAM[14] <= 0x2A, read back
        cpu_mi = 1; cpu_bus = 8'h0E;
        step();
        cpu_mi = 0; cpu_ri = 1; cpu_bus = 8'h2A;
        @(negedge clk);
        check("cpu_wr_addr", 32'(ram_addr), 32'h0E);
        check("cpu_wr_we", 32'(ram_we), 1);
        step();
        cpu_ri = 0; cpu_ro = 1; cpu_bus = 8'h00;
        @(negedge clk);
        check("cpu_rd_data", 32'(cpu_rdata), 32'h2A);
        check("cpu_rd_stall", 32'(cpu_stall), 0);
        check("cpu_mem14", 32'(mem[14]), 32'h2A);
        step();
        cpu_ro = 0;
        step();

        // Idle host read of RAM[3]
        s0 = stalls;
        host_start(1'b0, 4'd3, 8'h00, 8'h55, 2, 1'b1);
        host_wait_ack("idle_read");
        step();
        check("idle_no_stall", stalls - s0, 0);

        // Collision: host write 5 <= 0x77 while CPU reads MAR=5
        cpu_mi = 1; cpu_bus = 8'h05;
        step();
        cpu_mi = 0; cpu_bus = 8'h00;
        host_start(1'b1, 4'd5, 8'h77, 8'h55, 2, 1'b1);
        step();
        cpu_ro = 1; cpu_mi = 1; cpu_bus = 8'h0C;
        @(negedge clk);
        check("col_stall", 32'(cpu_stall), 1);
        check("col_ram_addr", 32'(ram_addr), 32'h05);
        check("col_ram_we", 32'(ram_we), 1);
        check("col_ram_wdata", 32'(ram_wdata), 32'h77);
        host_wait_ack("collision");
        check("col_retry_stall", 32'(cpu_stall), 0);
        check("col_retry_data", 32'(cpu_rdata), 32'h77);
        step();
        cpu_mi = 0; cpu_ro = 0; cpu_bus = 8'h00;
        step();

        // Starvation: CPU reads continuously, host read of RAM[14]
        cpu_ro = 1;
        s0 = stalls;
        host_start(1'b0, 4'd14, 8'h00, 8'h2A, 10, 1'b1);
        host_wait_ack("starve");
        step();
        cpu_ro = 0;
        step();
        check("starve_stalls", stalls - s0, 1);

        // Mid-access reset: host write 9 <= 0xFF aborted in ARB_HOST
        host_start(1'b1, 4'd9, 8'hFF, 8'h00, 0, 1'b0);
        step();
        rst = 1; host_bus.req = 0; cpu_ro = 1;
        @(negedge clk);
        check("mrst_ram_we", 32'(ram_we), 0);
        check("mrst_stall", 32'(cpu_stall), 0);
        check("mrst_ram_addr", 32'(ram_addr), 0);
        step();
        @(negedge clk);
        check("mrst_mem9", 32'(mem[9]), 32'h11);
        check("mrst_ack", 32'(host_bus.ack), 0);
        step();
        rst = 0; cpu_ro = 0;
        repeat (4) step();
        check("mrst_mem9_after", 32'(mem[9]), 32'h11);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
